// File: rtl/xor_frame_accumulator_if.sv
// Lane-word input and parity-result output handshake between the XOR stage,
// the frame accumulator and its downstream consumer.
interface xor_frame_accumulator_if #(
  parameter int LANES = 8
);
  logic [LANES-1:0] XOROUT;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] par_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output XOROUT, in_valid, out_ready,
    input  in_ready, par_out, out_valid
  );

  modport slave (
    input  XOROUT, in_valid, out_ready,
    output in_ready, par_out, out_valid
  );
endinterface

// File: rtl/xor_frame_accumulator.sv
// Folds XOROUT words into per-lane frame parity, buffers one result on a
// valid/ready port, and carries a 5-bit serial configuration chain.
module xor_frame_accumulator #(
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   configuration_input,
  input  logic                   configuration_enable,
  output logic                   configuration_output,
  xor_frame_accumulator_if.slave bus,
  output logic [CNT_W-1:0]       frame_count
);
  logic             invert_q, invert_d;
  logic [3:0]       frame_len_q, frame_len_d;
  logic [LANES-1:0] acc_q, acc_d;
  logic [3:0]       word_cnt_q, word_cnt_d;
  logic [LANES-1:0] par_out_q, par_out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             last;
  logic             in_ready;
  logic             accept;

  assign last     = (word_cnt_q == frame_len_q);
  // Only the frame-closing word needs a free (or draining) result buffer.
  assign in_ready = !configuration_enable && !(out_valid_q && !bus.out_ready && last);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    invert_d    = invert_q;
    frame_len_d = frame_len_q;
    if (configuration_enable) begin
      invert_d    = configuration_input;
      frame_len_d = {frame_len_q[2:0], invert_q};
    end
  end

  // The configuration chain is intentionally not reset so rst_n keeps the setup.
  always_ff @(posedge clk) begin
    invert_q    <= invert_d;
    frame_len_q <= frame_len_d;
  end

  always_comb begin
    acc_d         = acc_q;
    word_cnt_d    = word_cnt_q;
    par_out_d     = par_out_q;
    out_valid_d   = out_valid_q;
    frame_count_d = frame_count_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (configuration_enable) begin
      acc_d      = '0;
      word_cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        par_out_d     = acc_q ^ bus.XOROUT ^ {LANES{invert_q}};
        out_valid_d   = 1'b1;
        acc_d         = '0;
        word_cnt_d    = '0;
        frame_count_d = frame_count_q + CNT_W'(1);
      end else begin
        acc_d      = acc_q ^ bus.XOROUT;
        word_cnt_d = word_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q         <= '0;
      word_cnt_q    <= '0;
      par_out_q     <= '0;
      out_valid_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      acc_q         <= acc_d;
      word_cnt_q    <= word_cnt_d;
      par_out_q     <= par_out_d;
      out_valid_q   <= out_valid_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign configuration_output = frame_len_q[3];
  assign bus.in_ready         = in_ready;
  assign bus.par_out          = par_out_q;
  assign bus.out_valid        = out_valid_q;
  assign frame_count          = frame_count_q;
endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Self-checking bench for xor_frame_accumulator: directed vectors, corner
// sequences, a randomized frame-level reference model and a counter wrap run.
module tb_xor_frame_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_in = 1'b0;
  logic        cfg_en = 1'b0;
  logic        cfg_out;
  logic [15:0] frame_count;

  xor_frame_accumulator_if #(.LANES(8)) bus ();

  xor_frame_accumulator #(.LANES(8), .CNT_W(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .configuration_input  (cfg_in),
    .configuration_enable (cfg_en),
    .configuration_output (cfg_out),
    .bus                  (bus),
    .frame_count          (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  len;
    logic        inv;
    logic [31:0] w;
    logic [7:0]  exp;
  } vec_t;

  vec_t        vecs[5];
  int          total = 0;
  int          bad = 0;
  logic [4:0]  chain_m = '0;
  int          n_shifts = 0;
  logic [15:0] exp_fc = '0;
  logic [7:0]  fq[$];
  logic        pend = 1'b0;
  logic [7:0]  pend_val = '0;
  logic [7:0]  x;
  logic [3:0]  rlen;
  logic        rinv;
  logic        exp_rdy;
  logic [4:0]  cbits;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    cfg_en = 1'b1;
    cfg_in = b;
    #1;
    chk("cfg_in_ready", bus.in_ready, 0);
    tick();
    chain_m = {chain_m[3:0], b};
    n_shifts++;
    if (n_shifts >= 5) chk("cfg_out", cfg_out, chain_m[4]);
    cfg_en = 1'b0;
  endtask

  task automatic shift_cfg(input logic [3:0] len, input logic inv);
    shift_bit(len[3]);
    shift_bit(len[2]);
    shift_bit(len[1]);
    shift_bit(len[0]);
    shift_bit(inv);
    fq.delete();
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    bus.XOROUT   = w;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{len: 4'd3, inv: 1'b0, w: 32'h0F07_0301, exp: 8'h0A};
    vecs[1] = '{len: 4'd1, inv: 1'b1, w: 32'h0000_0FF0, exp: 8'h00};
    vecs[2] = '{len: 4'd2, inv: 1'b0, w: 32'h0056_3412, exp: 8'h70};
    vecs[3] = '{len: 4'd0, inv: 1'b0, w: 32'h0000_00C3, exp: 8'hC3};
    vecs[4] = '{len: 4'd3, inv: 1'b1, w: 32'h8080_8080, exp: 8'hFF};

    bus.XOROUT = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_par", bus.par_out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      shift_cfg(vecs[v].len, vecs[v].inv);
      bus.out_ready = 1'b1;
      for (int i = 0; i <= int'(vecs[v].len); i++) send(vecs[v].w[8*i +: 8]);
      exp_fc++;
      chk("vec_par", bus.par_out, vecs[v].exp);
      chk("vec_valid", bus.out_valid, 1);
      chk("vec_fc", frame_count, exp_fc);
      tick();
      chk("vec_valid_drop", bus.out_valid, 0);
    end

    // Odd parity, single-word frames back to back
    shift_cfg(4'd0, 1'b1);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.XOROUT = 8'h00; #1; chk("odd_ready0", bus.in_ready, 1); tick();
    chk("odd_par0", bus.par_out, 8'hFF);
    bus.XOROUT = 8'hFF; #1; chk("odd_ready1", bus.in_ready, 1); tick();
    chk("odd_par1", bus.par_out, 8'h00);
    bus.XOROUT = 8'h5A; #1; chk("odd_ready2", bus.in_ready, 1); tick();
    chk("odd_par2", bus.par_out, 8'hA5);
    chk("odd_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    exp_fc += 16'd3;
    chk("odd_fc", frame_count, exp_fc);
    tick();

    // Backpressure on the frame-closing word
    shift_cfg(4'd1, 1'b0);
    bus.out_ready = 1'b0;
    send(8'h11); send(8'h22);
    exp_fc++;
    chk("bp_par1", bus.par_out, 8'h33);
    chk("bp_fc1", frame_count, exp_fc);
    send(8'h44);
    chk("bp_hold_par", bus.par_out, 8'h33);
    chk("bp_hold_valid", bus.out_valid, 1);
    bus.XOROUT = 8'h0C; bus.in_valid = 1'b1; #1;
    chk("bp_stall0", bus.in_ready, 0);
    tick();
    chk("bp_stall1", bus.in_ready, 0);
    tick();
    chk("bp_stall2", bus.in_ready, 0);
    chk("bp_stall_par", bus.par_out, 8'h33);
    bus.out_ready = 1'b1; #1;
    chk("bp_release", bus.in_ready, 1);
    tick();
    exp_fc++;
    chk("bp_par2", bus.par_out, 8'h48);
    chk("bp_valid2", bus.out_valid, 1);
    chk("bp_fc2", frame_count, exp_fc);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drained", bus.out_valid, 0);

    // Reset in the middle of a frame
    shift_cfg(4'd3, 1'b0);
    bus.out_ready = 1'b1;
    send(8'h13); send(8'h57);
    rst_n = 1'b0;
    tick();
    exp_fc = '0;
    chk("mrst_par", bus.par_out, 0);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_fc", frame_count, 0);
    chk("mrst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h80);
    exp_fc++;
    chk("mrst_res_par", bus.par_out, 8'h00);
    chk("mrst_res_valid", bus.out_valid, 1);
    chk("mrst_res_fc", frame_count, exp_fc);
    tick();

    // Reconfiguration with a pending result and a partial frame
    shift_cfg(4'd1, 1'b0);
    bus.out_ready = 1'b0;
    send(8'h21); send(8'h12);
    exp_fc++;
    send(8'h40);
    cbits = 5'b00011;
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = (i == 2);
      if (i <= 2) begin
        chk("rcfg_pend_par", bus.par_out, 8'h33);
        chk("rcfg_pend_valid", bus.out_valid, 1);
      end
      shift_bit(cbits[4-i]);
      if (i >= 2) chk("rcfg_drained", bus.out_valid, 0);
    end
    chk("rcfg_fc", frame_count, exp_fc);
    bus.out_ready = 1'b1;
    send(8'h0F); send(8'h01);
    exp_fc++;
    chk("rcfg_new_par", bus.par_out, 8'hF1);
    chk("rcfg_new_fc", frame_count, exp_fc);
    tick();

    // Randomized traffic against a frame-level reference model
    pend = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rlen = (c == 0) ? 4'd15 : (c == 1) ? 4'($urandom_range(1, 14)) : 4'd2;
      rinv = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      shift_cfg(rlen, rinv);
      for (int k = 0; k < 200; k++) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.XOROUT    = 8'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        exp_rdy = !(pend && !bus.out_ready && fq.size() == int'(rlen));
        chk("rnd_in_ready", bus.in_ready, exp_rdy);
        if (pend && bus.out_ready) pend = 1'b0;
        if (bus.in_valid && exp_rdy) begin
          fq.push_back(bus.XOROUT);
          if (fq.size() == int'(rlen) + 1) begin
            x = rinv ? 8'hFF : 8'h00;
            foreach (fq[j]) x ^= fq[j];
            pend = 1'b1;
            pend_val = x;
            exp_fc++;
            fq.delete();
          end
        end
        tick();
        chk("rnd_valid", bus.out_valid, pend);
        if (pend) chk("rnd_par", bus.par_out, pend_val);
        chk("rnd_fc", frame_count, exp_fc);
      end
    end
    bus.in_valid = 1'b0;

    // Frame counter wrap with single-word frames
    bus.out_ready = 1'b1;
    shift_cfg(4'd0, 1'b0);
    bus.in_valid = 1'b1;
    while (exp_fc != 16'hFFFF) begin
      bus.XOROUT = 8'($urandom);
      tick();
      exp_fc++;
    end
    chk("wrap_ffff", frame_count, 16'hFFFF);
    tick();
    exp_fc++;
    chk("wrap_zero", frame_count, 16'h0000);
    chk("wrap_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
